// File: rtl/key_debounce_pulse_if.sv
// key_debounce_pulse_if
//   Bundles the raw key inputs and the conditioned key outputs of
//   key_debounce_pulse.
//   master : the side that drives the raw keys (board / testbench).
//   slave  : the debouncer itself.
//   key_in      raw, asynchronous, active-high button inputs
//   key_level   debounced key state
//   key_pulse   one-cycle strobe on an accepted press (and on auto-repeat)
//   key_release one-cycle strobe on an accepted release
`timescale 1ns/1ps

interface key_debounce_pulse_if #(
    parameter int KEYS = 2
);
    logic [KEYS-1:0] key_in;
    logic [KEYS-1:0] key_level;
    logic [KEYS-1:0] key_pulse;
    logic [KEYS-1:0] key_release;

    modport master (
        output key_in,
        input  key_level,
        input  key_pulse,
        input  key_release
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_pulse,
        output key_release
    );
endinterface

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse
//   Push-button conditioning. For every key it runs a 2-flop synchroniser,
//   a four-state debounce FSM (IDLE / CONFIRM_PRESS / PRESSED /
//   CONFIRM_RELEASE) and produces a debounced level plus registered
//   one-cycle press and release strobes. A level change is accepted only
//   after DEBOUNCE_CYCLES consecutive identical synchronised samples.
//
//   Optional feature macro: KEY_REPEAT_EN
//     When defined, a held key emits extra key_pulse strobes REPEAT_DELAY
//     cycles after the press strobe and then every REPEAT_PERIOD cycles
//     while the FSM stays in PRESSED or CONFIRM_RELEASE.
//
//   Ports:
//     clk  system clock
//     rst  asynchronous, active-high reset
//     bus  key_debounce_pulse_if.slave (key_in in; key_level, key_pulse,
//          key_release out)
`timescale 1ns/1ps

module key_debounce_pulse #(
    parameter int KEYS            = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                    clk,
    input  logic                    rst,
    key_debounce_pulse_if.slave     bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM_PRESS,
        PRESSED,
        CONFIRM_RELEASE
    } state_t;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
        $error("key_debounce_pulse: illegal parameter value");
    end

    for (genvar k = 0; k < KEYS; k++) begin : g_key
        localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic          s1, s2;
        state_t        state;
        logic [CW-1:0] cnt;
        logic          level_q, pulse_q, release_q;
        logic          rep_hit;

`ifdef KEY_REPEAT_EN
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW   = $clog2(RMAX) + 1;

        logic [RW-1:0] rcnt;
        logic          rfirst;  // next repeat is the first one (uses REPEAT_DELAY)
        logic          held;

        assign held    = (state == PRESSED) || (state == CONFIRM_RELEASE);
        assign rep_hit = held && (rcnt == (rfirst ? RW'(REPEAT_DELAY - 1)
                                                  : RW'(REPEAT_PERIOD - 1)));

        // The counter is zero on entry to PRESSED, so value k-1 before an
        // edge means k cycles have elapsed since the press strobe edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rcnt   <= '0;
                rfirst <= 1'b1;
            end else if (held) begin
                if (rep_hit) begin
                    rcnt   <= '0;
                    rfirst <= 1'b0;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end else begin
                rcnt   <= '0;
                rfirst <= 1'b1;
            end
        end
`else
        assign rep_hit = 1'b0;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1        <= 1'b0;
                s2        <= 1'b0;
                state     <= IDLE;
                cnt       <= '0;
                level_q   <= 1'b0;
                pulse_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments give every flop the
                // pre-edge value of the others, so s1 -> s2 is a real
                // two-stage pipeline regardless of statement order.
                s1 <= bus.key_in[k];
                s2 <= s1;
                // NOTE: strobes default low every cycle; only the branch
                // that accepts an edge raises them, which makes them
                // exactly one cycle wide.
                pulse_q   <= 1'b0;
                release_q <= 1'b0;

                case (state)
                    IDLE: begin
                        if (s2) begin
                            state <= CONFIRM_PRESS;
                            cnt   <= CW'(1);
                        end
                    end
                    CONFIRM_PRESS: begin
                        if (!s2) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == LAST) begin
                            state   <= PRESSED;
                            cnt     <= '0;
                            level_q <= 1'b1;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PRESSED: begin
                        pulse_q <= rep_hit;
                        if (!s2) begin
                            state <= CONFIRM_RELEASE;
                            cnt   <= CW'(1);
                        end
                    end
                    CONFIRM_RELEASE: begin
                        if (s2) begin
                            state   <= PRESSED;
                            cnt     <= '0;
                            pulse_q <= rep_hit;
                        end else if (cnt == LAST) begin
                            // Release wins over a coincident repeat so the
                            // two strobes are never high together.
                            state     <= IDLE;
                            cnt       <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            pulse_q <= rep_hit;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign bus.key_level[k]   = level_q;
        assign bus.key_pulse[k]   = pulse_q;
        assign bus.key_release[k] = release_q;
    end

endmodule
